// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with pending-bit tracking; define REGFILE_BYPASS_EN for same-cycle write-to-read bypass
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     cnt_nxt;

  logic wr0_ok, wr1_ok, rsv_ok;
  assign wr0_ok = we0 && (wa0 != '0);
  assign wr1_ok = we1 && (wa1 != '0);
  assign rsv_ok = rsv_valid && (rsv_addr != '0);

  // Writes retire a producer; a same-cycle reserve starts a new one, so it is applied last.
  always_comb begin
    pend_nxt = pend;
    if (wr0_ok) pend_nxt[wa0] = 1'b0;
    if (wr1_ok) pend_nxt[wa1] = 1'b0;
    if (rsv_ok) pend_nxt[rsv_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr0_ok) mem[wa0] <= wd0;
      if (wr1_ok) mem[wa1] <= wd1;
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = ra[g*AW +: AW];

    always_comb begin
      d = mem[a];
      b = pend[a];
`ifdef REGFILE_BYPASS_EN
      // Port 1 is checked last so it wins over port 0, matching the stored result.
      if (we0 && (wa0 == a)) begin
        d = wd0;
        b = rsv_valid && (rsv_addr == a);
      end
      if (we1 && (wa1 == a)) begin
        d = wd1;
        b = rsv_valid && (rsv_addr == a);
      end
`endif
      if (a == '0) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd[g*XLEN +: XLEN] = d;
    assign rbusy[g]           = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (honours REGFILE_BYPASS_EN)
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                we0, we1, rsv_valid;
  logic [AW-1:0]       wa0, wa1, rsv_addr;
  logic [XLEN-1:0]     wd0, wd1;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic [AW:0]         pend_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  logic [XLEN-1:0] m_mem [NREG];
  logic [NREG-1:0] m_pend;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .ra(ra), .rd(rd), .rbusy(rbusy), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [AW-1:0] a);
    logic [31:0] v;
    if (a == '0) return 32'h0;
    v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    if (we0 && wa0 == a) v = wd0;
    if (we1 && wa1 == a) v = wd1;
`endif
    return v;
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((we0 && wa0 == a) || (we1 && wa1 == a)) return rsv_valid && (rsv_addr == a);
`endif
    return m_pend[a];
  endfunction

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; rsv_valid = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; rsv_addr = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  // Push expectations for the current inputs, pop them against the DUT, then advance one edge.
  task automatic step(input bit check = 1'b1);
    exp_t e;
    #1;
    if (check) begin
      for (int p = 0; p < NRD; p++) begin
        e.tag = $sformatf("rd%0d_a%0d", p, ra[p*AW +: AW]);
        e.val = m_rd(ra[p*AW +: AW]);
        sb.push_back(e);
        e.tag = $sformatf("rbusy%0d_a%0d", p, ra[p*AW +: AW]);
        e.val = 32'(m_busy(ra[p*AW +: AW]));
        sb.push_back(e);
      end
      e.tag = "pend_cnt";
      e.val = 32'($countones(m_pend));
      sb.push_back(e);
      for (int p = 0; p < NRD; p++) begin
        e = sb.pop_front();
        chk(e.tag, rd[p*XLEN +: XLEN], e.val);
        e = sb.pop_front();
        chk(e.tag, 32'(rbusy[p]), e.val);
      end
      e = sb.pop_front();
      chk(e.tag, 32'(pend_cnt), e.val);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      m_pend = '0;
    end else begin
      if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; m_pend[wa0] = 1'b0; end
      if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_pend[wa1] = 1'b0; end
      if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_pend = '0;
    idle();
    set_ra(0, 0);
    rst = 1'b1;
    step(1'b0);
    step();
    idle();

    for (int k = 0; k < NREG / 2; k++) begin
      set_ra(AW'(2 * k), AW'(2 * k + 1));
      #1;
      chk("rst_rd0", rd[31:0], 32'h0);
      chk("rst_busy", 32'(rbusy), 32'h0);
      step();
    end
    chk("rst_cnt", 32'(pend_cnt), 32'h0);

    we0 = 1'b1; wa0 = 5; wd0 = 32'hDEADBEEF; set_ra(5, 0);
    step();
    idle();
    #1;
    chk("wr5", rd[31:0], 32'hDEADBEEF);
    step();
    we0 = 1'b1; wa0 = 0; wd0 = 32'h1; set_ra(0, 0);
    step();
    idle();
    step();
    #1;
    chk("wr0_ignored", rd[31:0], 32'h0);

    we0 = 1'b1; wa0 = 7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 7; wd1 = 32'h22;
    step();
    idle(); set_ra(7, 7);
    #1;
    chk("dual_wr7", rd[63:32], 32'h22);
    step();

    rsv_valid = 1'b1; rsv_addr = 3; step();
    rsv_addr = 4; step();
    idle(); set_ra(3, 4);
    #1;
    chk("cnt_two", 32'(pend_cnt), 32'd2);
    chk("busy3", 32'(rbusy[0]), 32'd1);
    step();
    we0 = 1'b1; wa0 = 3; wd0 = 32'h55; step();
    idle();
    #1;
    chk("cnt_after_wr3", 32'(pend_cnt), 32'd1);
    chk("busy3_clr", 32'(rbusy[0]), 32'd0);
    step();
    rsv_valid = 1'b1; rsv_addr = 4; we0 = 1'b1; wa0 = 4; wd0 = 32'h44; step();
    idle(); set_ra(4, 4);
    #1;
    chk("cnt_rsv_wr4", 32'(pend_cnt), 32'd1);
    chk("busy4_rsv_wins", 32'(rbusy[1]), 32'd1);
    step();

    we0 = 1'b1; wa0 = 9; wd0 = 32'hA5A5A5A5; set_ra(0, 9);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp9_same", rd[63:32], 32'hA5A5A5A5);
`else
    chk("byp9_same", rd[63:32], 32'h0);
`endif
    step();
    idle();
    #1;
    chk("byp9_next", rd[63:32], 32'hA5A5A5A5);
    step();

    we0 = 1'b1; wa0 = 2; wd0 = 32'h1234; step();
    idle(); rsv_valid = 1'b1; rsv_addr = 2; step();
    idle(); rst = 1'b1; we0 = 1'b1; wa0 = 2; wd0 = 32'hFF; set_ra(2, 9);
    step();
    idle();
    #1;
    chk("rst_prio_rd2", rd[31:0], 32'h0);
    chk("rst_prio_cnt", 32'(pend_cnt), 32'h0);
    step();

    for (int i = 0; i < NREG; i++) begin
      rsv_valid = 1'b1; rsv_addr = AW'(i); step();
    end
    rsv_addr = 5; step();
    idle();
    #1;
    chk("cnt_full", 32'(pend_cnt), 32'(NREG - 1));
    step();

    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      we0       = $urandom_range(0, 1);
      we1       = $urandom_range(0, 1);
      rsv_valid = $urandom_range(0, 1);
      wa0       = AW'($urandom_range(0, 7));
      wa1       = AW'($urandom_range(0, 7));
      rsv_addr  = AW'($urandom_range(0, 7));
      wd0       = $urandom;
      wd1       = $urandom;
      set_ra(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      step();
    end
    idle();
    step();

    if (sb.size() != 0) chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
